// File: rtl/subckt_pattern_driver.sv
`default_nettype none
// ============================================================================
// Module   : subckt_pattern_driver
// Brief    : LFSR stimulus driver with LAT-aligned MISR response compaction.
//            Optional golden-signature compare via macro PDRV_GOLDEN_CMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module subckt_pattern_driver #(
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter int          PAT_COUNT = 255,
    parameter int          LAT       = 2
`ifdef PDRV_GOLDEN_CMP_EN
    ,
    parameter logic [15:0] GOLDEN    = 16'h0000
`endif
) (
    input  logic        I1470_clk,
    input  logic        I1477_rst,
    input  logic        start,
    output logic [2:0]  stim,
    input  logic        resp,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
`ifdef PDRV_GOLDEN_CMP_EN
    ,
    output logic        match
`endif
);

    localparam logic [7:0]  C_PAT_LAST  = 8'(PAT_COUNT - 1);
    localparam logic [7:0]  C_LAT_LAST  = 8'(LAT - 1);
    localparam logic [15:0] C_MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_lfsr;
    logic [7:0]     r_cnt;
    logic [15:0]    r_sig;
    logic [15:0]    w_sig_nxt;
    logic [LAT-1:0] r_vld;
    logic           w_start_acc;
    logic           w_drive;
    logic           w_cap_en;
    logic           w_last;

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_last marks the final cycle of a timed phase and restarts the counter
    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        stim        = 3'b000;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                stim   = r_lfsr[2:0];
                busy   = 1'b1;
                w_last = (r_cnt == C_PAT_LAST);
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy   = 1'b1;
                w_last = (r_cnt == C_LAT_LAST);
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_drive     = (r_state == S_DRIVE);
    assign w_cap_en    = r_vld[LAT-1];

    assign w_sig_nxt = w_cap_en
                     ? ({r_sig[14:0], 1'b0} ^ (r_sig[15] ? C_MISR_POLY : 16'h0000)
                        ^ {15'b0, resp})
                     : r_sig;

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            r_lfsr <= SEED;
            r_cnt  <= '0;
            r_sig  <= '0;
        end else begin
            if (w_start_acc) begin
                r_lfsr <= SEED;
                r_sig  <= '0;
            end else begin
                if (w_drive) begin
                    r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
                end
                r_sig <= w_sig_nxt;
            end
            if (w_start_acc || w_last) begin
                r_cnt <= '0;
            end else if (busy) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Delay the DRIVE flag by the subcircuit latency so capture lines up with resp
    generate
        if (LAT == 1) begin : g_cap_lat1
            always_ff @(posedge I1470_clk) begin
                if (I1477_rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= w_drive;
                end
            end
        end else begin : g_cap_latn
            always_ff @(posedge I1470_clk) begin
                if (I1477_rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= {r_vld[LAT-2:0], w_drive};
                end
            end
        end
    endgenerate

    assign signature = r_sig;

`ifdef PDRV_GOLDEN_CMP_EN
    logic r_match;

    // Compare the value being loaded on the DRAIN->DONE edge so match is valid in DONE
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            r_match <= 1'b0;
        end else if (w_start_acc) begin
            r_match <= 1'b0;
        end else if ((r_state == S_DRAIN) && (w_state_nxt == S_DONE)) begin
            r_match <= (w_sig_nxt == GOLDEN);
        end
    end

    assign match = r_match;
`endif

endmodule
`default_nettype wire

// File: doc/subckt_pattern_driver.md
SUBCKT_PATTERN_DRIVER -- requirements
Module: subckt_pattern_driver

Interface
REQ-001 The block SHALL have parameter SEED, default 8'hA5, giving the nonzero LFSR start state loaded on each start.
REQ-002 The block SHALL have parameter PAT_COUNT, default 255, range 1..255, giving the number of patterns applied per run.
REQ-003 The block SHALL have parameter LAT, default 2, range 1..7, giving the subcircuit response latency in clock cycles.
REQ-004 The block SHALL have port I1470_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port I1477_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-007 The block SHALL have port stim, output, 3 bits: pattern to the subcircuit data inputs, with bit2 to the first data input, bit1 to the second and bit0 to the third.
REQ-008 The block SHALL have port resp, input, 1 bit: registered subcircuit output.
REQ-009 The block SHALL have port busy, output, 1 bit: high in DRIVE and DRAIN.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle end-of-run pulse.
REQ-011 The block SHALL have port signature, output, 16 bits: the MISR state.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, DRIVE, DRAIN and DONE.
REQ-013 In IDLE with start=1, the next state SHALL be DRIVE, lfsr SHALL load SEED, signature SHALL clear to 0 and the pattern counter SHALL clear to 0.
REQ-014 In DRIVE, stim SHALL equal lfsr[2:0] each cycle and lfsr SHALL advance to {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-015 DRIVE SHALL last exactly PAT_COUNT cycles and then go to DRAIN.
REQ-016 stim SHALL be 3'b000 in every state other than DRIVE.
REQ-017 DRAIN SHALL last exactly LAT cycles and then go to DONE; DONE SHALL last one cycle with done=1 and then go to IDLE.
REQ-018 A LAT-deep shift register of the DRIVE-valid flag SHALL produce cap_en, so that resp is compacted exactly PAT_COUNT times: on the cycles LAT..LAT+PAT_COUNT-1 after DRIVE entry.
REQ-019 When cap_en=1, the compaction SHALL be signature_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, resp}; otherwise signature SHALL hold.
REQ-020 signature SHALL hold its final value from DONE until the next accepted start.
REQ-021 start asserted while busy or done is high SHALL be ignored, with no queuing.
REQ-022 start held high continuously SHALL begin a new run on each IDLE cycle, giving back-to-back runs separated by exactly one IDLE cycle.

Reset
REQ-023 While I1477_rst=1 at a clock edge, the block SHALL set state=IDLE, lfsr=SEED, counters=0, cap_en pipeline=0, stim=0, busy=0, done=0 and signature=16'h0000.
REQ-024 Reset asserted mid-run SHALL abort the run at the next edge with no done pulse, and the discarded partial signature SHALL not be visible after reset.

Configuration
REQ-025 With macro PDRV_GOLDEN_CMP_EN defined, the block SHALL add parameter GOLDEN (16 bits, default 16'h0000) and output match (1 bit), registered high in the DONE cycle if signature_next == GOLDEN, held until the next start or reset, and reset to 0.
REQ-026 Without PDRV_GOLDEN_CMP_EN, the match port and GOLDEN parameter SHALL not exist and the behaviour of all other ports SHALL be unchanged.

Verification
REQ-027 The bench SHALL cover: reset, then start pulse with SEED=8'hA5 -> first DRIVE cycle stim=3'b101, second stim=3'b010 (lfsr 8'h4A), busy=1.
REQ-028 The bench SHALL cover: PAT_COUNT=4, LAT=2, resp tied 1 -> done exactly 7 cycles after start is sampled (4 DRIVE + 2 DRAIN + DONE), signature=16'h000F.
REQ-029 The bench SHALL cover: PAT_COUNT=255, resp tied 0 -> signature=16'h0000, done pulse width 1, busy low in the DONE cycle.
REQ-030 The bench SHALL cover: start pulsed during DRIVE -> no effect; run length and signature identical to an undisturbed run.
REQ-031 The bench SHALL cover: I1477_rst=1 for 1 cycle at DRIVE cycle 10 -> next cycle state IDLE, stim=0, signature=0, no done pulse; a new start then reproduces the undisturbed signature.
REQ-032 The bench SHALL cover: PDRV_GOLDEN_CMP_EN with GOLDEN=16'h000F, PAT_COUNT=4, resp=1 -> match=1 at DONE; with resp=0 -> match=0.
